gc_dispatcher: RTL and testbench

GC_DISPATCHER -- requirements
Module: gc_dispatcher

---
 rtl/gc_dispatcher.sv | 122 ++++++++++++
 tb/tb_gc_dispatcher.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gc_dispatcher.sv
// Loop-iteration dispatcher: hands out gc, gc+gd, gc+2gd, ... to requesting cores
// in priority order until the counter leaves [gc, limit), one fork at a time.
module gc_dispatcher #(
  parameter int N_CORE   = 4,
  parameter int GC_WIDTH = 32,
  parameter int GD_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fork_valid,
  input  logic [GC_WIDTH-1:0]          fork_gc,
  input  logic [GD_WIDTH-1:0]          fork_gd,
  input  logic [GC_WIDTH-1:0]          fork_limit,
  input  logic [N_CORE-1:0]            req_valid,
  output logic [N_CORE-1:0]            grant_valid,
  output logic [N_CORE*GC_WIDTH-1:0]   grant_gc,
  output logic                         active,
  output logic                         exhausted,
  output logic [GC_WIDTH-1:0]          issued_count
);

  localparam int CW = $clog2(N_CORE + 1);
  localparam int XW = GC_WIDTH + GD_WIDTH + CW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [GC_WIDTH-1:0]   r_gc;
  logic [GD_WIDTH-1:0]   r_gd;
  logic [GC_WIDTH-1:0]   r_limit;
  logic [GC_WIDTH-1:0]   r_issued;

  logic signed [XW-1:0]  w_gd_x;
  logic signed [XW-1:0]  w_limit_x;
  logic signed [XW-1:0]  w_next_gc_x;
  logic [N_CORE-1:0]     w_grant;
  logic [N_CORE*GC_WIDTH-1:0] w_grant_gc;
  logic [CW-1:0]         w_m;
  logic                  w_fork_in_range;

  function automatic logic signed [XW-1:0] sx_gc(input logic [GC_WIDTH-1:0] v);
    return {{(XW-GC_WIDTH){v[GC_WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [XW-1:0] sx_gd(input logic [GD_WIDTH-1:0] v);
    return {{(XW-GD_WIDTH){v[GD_WIDTH-1]}}, v};
  endfunction

  function automatic logic in_range(input logic signed [XW-1:0] v,
                                    input logic signed [XW-1:0] gd,
                                    input logic signed [XW-1:0] lim);
    return ((gd > 0) && (v < lim)) || ((gd < 0) && (v > lim));
  endfunction

  assign w_gd_x          = sx_gd(r_gd);
  assign w_limit_x       = sx_gc(r_limit);
  assign w_fork_in_range = in_range(sx_gc(fork_gc), sx_gd(fork_gd), sx_gc(fork_limit));

  // Walk cores in priority order; the candidate only advances past granted cores,
  // so it ends the loop as next cycle's gc without needing a multiplier.
  always_comb begin
    logic signed [XW-1:0] w_cand;
    w_grant    = '0;
    w_grant_gc = '0;
    w_m        = '0;
    w_cand     = sx_gc(r_gc);
    for (int unsigned i = 0; i < N_CORE; i++) begin
      w_grant_gc[i*GC_WIDTH +: GC_WIDTH] = w_cand[GC_WIDTH-1:0];
      if ((r_state == S_RUN) && !fork_valid && req_valid[i] &&
          in_range(w_cand, w_gd_x, w_limit_x)) begin
        w_grant[i] = 1'b1;
        w_cand     = w_cand + w_gd_x;
        w_m        = w_m + CW'(1);
      end
    end
    w_next_gc_x = w_cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (fork_valid) begin
      w_next_state = ((fork_gd == '0) || !w_fork_in_range) ? S_DONE : S_RUN;
    end else if ((r_state == S_RUN) && !in_range(w_next_gc_x, w_gd_x, w_limit_x)) begin
      w_next_state = S_DONE;
    end
  end

  always_comb begin
    active       = (r_state == S_RUN);
    exhausted    = (r_state == S_DONE);
    grant_valid  = w_grant;
    grant_gc     = w_grant_gc;
    issued_count = r_issued;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gc     <= '0;
      r_gd     <= '0;
      r_limit  <= '0;
      r_issued <= '0;
    end else if (fork_valid) begin
      r_gc     <= fork_gc;
      r_gd     <= fork_gd;
      r_limit  <= fork_limit;
      r_issued <= '0;
    end else if (r_state == S_RUN) begin
      r_gc     <= w_next_gc_x[GC_WIDTH-1:0];
      r_issued <= r_issued + GC_WIDTH'(w_m);
    end
  end

endmodule

// File: tb/tb_gc_dispatcher.sv
// Bench for gc_dispatcher: directed scenarios plus a randomized run checked
// against an arithmetic model of the iteration space.
module tb_gc_dispatcher;

  logic         clk;
  logic         rst_n;
  logic         fork_valid;
  logic [31:0]  fork_gc, fork_gd, fork_limit;
  logic [3:0]   req_valid;
  logic [3:0]   grant_valid;
  logic [127:0] grant_gc;
  logic         active, exhausted;
  logic [31:0]  issued_count;

  logic         f8_valid;
  logic [7:0]   f8_gc, f8_gd, f8_limit;
  logic [3:0]   g8_valid;
  logic [31:0]  g8_gc;
  logic         a8, x8;
  logic [7:0]   ic8;

  int n_cmp = 0;
  int n_err = 0;

  gc_dispatcher #(.N_CORE(4), .GC_WIDTH(32), .GD_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .fork_valid(fork_valid), .fork_gc(fork_gc),
    .fork_gd(fork_gd), .fork_limit(fork_limit), .req_valid(req_valid),
    .grant_valid(grant_valid), .grant_gc(grant_gc), .active(active),
    .exhausted(exhausted), .issued_count(issued_count));

  gc_dispatcher #(.N_CORE(4), .GC_WIDTH(8), .GD_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .fork_valid(f8_valid), .fork_gc(f8_gc),
    .fork_gd(f8_gd), .fork_limit(f8_limit), .req_valid(req_valid),
    .grant_valid(g8_valid), .grant_gc(g8_gc), .active(a8),
    .exhausted(x8), .issued_count(ic8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [31:0] gc, input logic [31:0] gd,
                       input logic [31:0] lim, input logic [3:0] rq);
    fork_valid = fv; fork_gc = gc; fork_gd = gd; fork_limit = lim; req_valid = rq;
  endtask

  function automatic bit inr(input longint v, input longint gd, input longint lim);
    return ((gd > 0) && (v < lim)) || ((gd < 0) && (v > lim));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 4'hF);
    f8_valid = 1'b0; f8_gc = '0; f8_gd = '0; f8_limit = '0;
    #12;
    n_cmp++; if (grant_valid !== 4'h0) begin n_err++; $display("FAIL reset_gv got %h expected 0", grant_valid); end
    n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL reset_active got %b expected 0", active); end
    n_cmp++; if (exhausted !== 1'b0) begin n_err++; $display("FAIL reset_exh got %b expected 0", exhausted); end
    n_cmp++; if (issued_count !== 32'd0) begin n_err++; $display("FAIL reset_issued got %0d expected 0", issued_count); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unit_stride();
    drive(1'b1, 32'd0, 32'd1, 32'd10, 4'hF);
    #2;
    n_cmp++; if (grant_valid !== 4'h0) begin n_err++; $display("FAIL fork_cycle_gv got %h expected 0", grant_valid); end
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 4'hF);
    #2;
    n_cmp++; if (active !== 1'b1) begin n_err++; $display("FAIL us_active got %b expected 1", active); end
    n_cmp++; if (grant_valid !== 4'hF) begin n_err++; $display("FAIL us_gv0 got %h expected f", grant_valid); end
    n_cmp++; if (grant_gc !== {32'd3, 32'd2, 32'd1, 32'd0}) begin n_err++; $display("FAIL us_gc0 got %h expected 0..3", grant_gc); end
    tick(); #2;
    n_cmp++; if (grant_valid !== 4'hF) begin n_err++; $display("FAIL us_gv1 got %h expected f", grant_valid); end
    n_cmp++; if (grant_gc !== {32'd7, 32'd6, 32'd5, 32'd4}) begin n_err++; $display("FAIL us_gc1 got %h expected 4..7", grant_gc); end
    tick(); #2;
    n_cmp++; if (grant_valid !== 4'h3) begin n_err++; $display("FAIL us_gv2 got %h expected 3", grant_valid); end
    n_cmp++; if (grant_gc !== {32'd10, 32'd10, 32'd9, 32'd8}) begin n_err++; $display("FAIL us_gc2 got %h expected 10,10,9,8", grant_gc); end
    tick(); #2;
    n_cmp++; if (exhausted !== 1'b1) begin n_err++; $display("FAIL us_exh got %b expected 1", exhausted); end
    n_cmp++; if (grant_valid !== 4'h0) begin n_err++; $display("FAIL us_gv3 got %h expected 0", grant_valid); end
    n_cmp++; if (issued_count !== 32'd10) begin n_err++; $display("FAIL us_issued got %0d expected 10", issued_count); end
    tick();
  endtask

  task automatic test_sparse_req();
    drive(1'b1, 32'd0, 32'd3, 32'd10, 4'hA);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 4'hA);
    #2;
    n_cmp++; if (grant_valid !== 4'hA) begin n_err++; $display("FAIL sp_gv0 got %h expected a", grant_valid); end
    n_cmp++; if (grant_gc !== {32'd3, 32'd3, 32'd0, 32'd0}) begin n_err++; $display("FAIL sp_gc0 got %h expected 3,3,0,0", grant_gc); end
    tick(); #2;
    n_cmp++; if (grant_valid !== 4'hA) begin n_err++; $display("FAIL sp_gv1 got %h expected a", grant_valid); end
    n_cmp++; if (grant_gc !== {32'd9, 32'd9, 32'd6, 32'd6}) begin n_err++; $display("FAIL sp_gc1 got %h expected 9,9,6,6", grant_gc); end
    tick(); #2;
    n_cmp++; if (exhausted !== 1'b1) begin n_err++; $display("FAIL sp_exh got %b expected 1", exhausted); end
    n_cmp++; if (issued_count !== 32'd4) begin n_err++; $display("FAIL sp_issued got %0d expected 4", issued_count); end
    tick();
  endtask

  task automatic test_narrow_width();
    req_valid = 4'hF;
    f8_valid = 1'b1; f8_gc = 8'd10; f8_gd = 8'hFE; f8_limit = 8'd3;
    tick();
    f8_valid = 1'b0;
    #2;
    n_cmp++; if (g8_valid !== 4'hF) begin n_err++; $display("FAIL n8_gv0 got %h expected f", g8_valid); end
    n_cmp++; if (g8_gc !== {8'd4, 8'd6, 8'd8, 8'd10}) begin n_err++; $display("FAIL n8_gc0 got %h expected 0406080a", g8_gc); end
    tick(); #2;
    n_cmp++; if (x8 !== 1'b1) begin n_err++; $display("FAIL n8_exh got %b expected 1", x8); end
    n_cmp++; if (ic8 !== 8'd4) begin n_err++; $display("FAIL n8_issued got %0d expected 4", ic8); end
    f8_valid = 1'b1; f8_gc = 8'h7E; f8_gd = 8'd1; f8_limit = 8'h7F;
    tick();
    f8_valid = 1'b0;
    #2;
    n_cmp++; if (g8_valid !== 4'h1) begin n_err++; $display("FAIL n8_gv1 got %h expected 1", g8_valid); end
    n_cmp++; if (g8_gc !== 32'h7F7F7F7E) begin n_err++; $display("FAIL n8_gc1 got %h expected 7f7f7f7e", g8_gc); end
    tick(); #2;
    n_cmp++; if (g8_valid !== 4'h0) begin n_err++; $display("FAIL n8_nowrap got %h expected 0", g8_valid); end
    n_cmp++; if (x8 !== 1'b1 || ic8 !== 8'd1) begin n_err++; $display("FAIL n8_done got exh=%b issued=%0d expected exh=1 issued=1", x8, ic8); end
    tick();
  endtask

  task automatic test_empty_fork();
    drive(1'b1, 32'd5, 32'd0, 32'd10, 4'hF);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 4'hF);
    #2;
    n_cmp++; if (exhausted !== 1'b1 || grant_valid !== 4'h0) begin n_err++; $display("FAIL ef_gd0 got exh=%b gv=%h expected exh=1 gv=0", exhausted, grant_valid); end
    drive(1'b1, 32'd5, 32'd1, 32'd5, 4'hF);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 4'hF);
    #2;
    n_cmp++; if (exhausted !== 1'b1 || grant_valid !== 4'h0) begin n_err++; $display("FAIL ef_oor got exh=%b gv=%h expected exh=1 gv=0", exhausted, grant_valid); end
    drive(1'b1, -32'sd4, 32'd1, 32'd5, 4'hF);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 4'hF);
    #2;
    n_cmp++; if (active !== 1'b1) begin n_err++; $display("FAIL ef_refork got %b expected 1", active); end
    tick();
  endtask

  task automatic test_mid_run_fork();
    drive(1'b1, 32'd0, 32'd1, 32'd100, 4'hF);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 4'hF);
    tick();
    drive(1'b1, 32'd50, 32'd2, 32'd60, 4'hF);
    #2;
    n_cmp++; if (grant_valid !== 4'h0) begin n_err++; $display("FAIL mf_gv got %h expected 0", grant_valid); end
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 4'hF);
    #2;
    n_cmp++; if (issued_count !== 32'd0) begin n_err++; $display("FAIL mf_issued got %0d expected 0", issued_count); end
    n_cmp++; if (grant_gc !== {32'd56, 32'd54, 32'd52, 32'd50}) begin n_err++; $display("FAIL mf_gc got %h expected 50,52,54,56", grant_gc); end
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'd0, 32'd1, 32'd100, 4'hF);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 4'hF);
    #2;
    n_cmp++; if (grant_valid !== 4'hF) begin n_err++; $display("FAIL ar_pre got %h expected f", grant_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (grant_valid !== 4'h0) begin n_err++; $display("FAIL ar_drop got %h expected 0", grant_valid); end
    n_cmp++; if (active !== 1'b0 || issued_count !== 32'd0) begin n_err++; $display("FAIL ar_state got act=%b issued=%0d expected 0 0", active, issued_count); end
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); #2;
    n_cmp++; if (grant_valid !== 4'h0 || active !== 1'b0 || exhausted !== 1'b0) begin n_err++; $display("FAIL ar_idle got gv=%h act=%b exh=%b expected 0", grant_valid, active, exhausted); end
    drive(1'b1, 32'd7, 32'd1, 32'd20, 4'hF);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 4'hF);
    #2;
    n_cmp++; if (grant_gc !== {32'd10, 32'd9, 32'd8, 32'd7} || grant_valid !== 4'hF) begin n_err++; $display("FAIL ar_fork gv=%h gc=%h expected f 7..10", grant_valid, grant_gc); end
    tick();
  endtask

  task automatic test_random();
    longint m_gc, m_gd, m_lim, m_iss, v;
    int     m_mode, k, fgc, fgd, flim;
    logic   fv;
    logic [3:0]   rq, egv;
    logic [127:0] egc;
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 4'h0);
    #2;
    rst_n = 1'b1;
    tick();
    m_gc = 0; m_gd = 0; m_lim = 0; m_iss = 0; m_mode = 0;
    for (int c = 0; c < 400; c++) begin
      fv   = ($urandom_range(0, 5) == 0);
      fgc  = int'($urandom_range(0, 40)) - 20;
      fgd  = int'($urandom_range(0, 8)) - 4;
      flim = int'($urandom_range(0, 60)) - 30;
      rq   = 4'($urandom_range(0, 15));
      drive(fv, fgc, fgd, flim, rq);
      #2;
      k = 0; egv = '0; egc = '0;
      for (int i = 0; i < 4; i++) begin
        v = m_gc + longint'(k) * m_gd;
        egc[i*32 +: 32] = v[31:0];
        if (!fv && m_mode == 1 && rq[i] && inr(v, m_gd, m_lim)) begin
          egv[i] = 1'b1;
          k++;
        end
      end
      n_cmp++; if (grant_valid !== egv) begin n_err++; $display("FAIL rnd_gv c=%0d got %h expected %h", c, grant_valid, egv); end
      n_cmp++; if (grant_gc !== egc) begin n_err++; $display("FAIL rnd_gc c=%0d got %h expected %h", c, grant_gc, egc); end
      n_cmp++; if (active !== (m_mode == 1)) begin n_err++; $display("FAIL rnd_active c=%0d got %b expected %b", c, active, m_mode == 1); end
      n_cmp++; if (exhausted !== (m_mode == 2)) begin n_err++; $display("FAIL rnd_exh c=%0d got %b expected %b", c, exhausted, m_mode == 2); end
      n_cmp++; if (issued_count !== m_iss[31:0]) begin n_err++; $display("FAIL rnd_issued c=%0d got %0d expected %0d", c, issued_count, m_iss); end
      if (fv) begin
        m_gc = fgc; m_gd = fgd; m_lim = flim; m_iss = 0;
        m_mode = (fgd == 0 || !inr(m_gc, m_gd, m_lim)) ? 2 : 1;
      end else if (m_mode == 1) begin
        m_gc  = m_gc + longint'(k) * m_gd;
        m_iss = m_iss + k;
        if (!inr(m_gc, m_gd, m_lim)) m_mode = 2;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_unit_stride();
    test_sparse_req();
    test_narrow_width();
    test_empty_fork();
    test_mid_run_fork();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
